pc_sequencer: RTL and testbench

- Program-counter stage directly upstream of jump_shift.
- Holds the architectural PC and produces PC+4. It feeds PC+4[31:28] to jump_shift as the address remainder.
- Consumes jump_shift's 32-bit target plus branch and jump-register redirects, and selects the next PC.
- Adds stall handling with a pending-redirect latch, a fetch-valid qualifier and an advance counter for the instruction memory / retire path.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer_next_sel.sv | 36 +++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } redir_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect inputs and PC outputs of the PC sequencer
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_imm;
  logic             jump;
  logic [31:0]      jump_target;
  logic             jump_reg;
  logic [31:0]      reg_target;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [3:0]       pc_upper;
  logic             fetch_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] adv_count;

  modport master (
    output stall, branch_taken, branch_imm, jump, jump_target, jump_reg, reg_target,
    input  pc, pc_plus4, pc_upper, fetch_valid, misalign_err, adv_count
  );

  modport slave (
    input  stall, branch_taken, branch_imm, jump, jump_target, jump_reg, reg_target,
    output pc, pc_plus4, pc_upper, fetch_valid, misalign_err, adv_count
  );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// rtl/pc_sequencer_next_sel.sv - next-PC priority mux and branch adder
module pc_next_sel
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_taken_i,
  input  logic [29:0] branch_imm_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jump_reg_i,
  input  logic [29:0] reg_word_i,
  output logic [31:0] next_pc_o,
  output redir_sel_e  sel_o
);

  logic [31:0] branch_pc;

  // Immediate is in words; bits shifted out above [29] are lost by the 32-bit wrap.
  assign branch_pc = pc_plus4_i + {branch_imm_i, 2'b00};

  always_comb begin
    sel_o     = SEL_SEQ;
    next_pc_o = pc_plus4_i;
    if (jump_reg_i) begin
      sel_o     = SEL_JR;
      next_pc_o = {reg_word_i, 2'b00};
    end else if (jump_i) begin
      sel_o     = SEL_J;
      next_pc_o = jump_target_i;
    end else if (branch_taken_i) begin
      sel_o     = SEL_BR;
      next_pc_o = branch_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC with stall, pending redirect and advance count
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  redir_sel_e       sel;
  logic             redirect;

  assign pc_plus4 = pc_q + PC_STEP;
  assign redirect = (sel != SEL_SEQ);

  pc_next_sel u_next_sel (
    .pc_plus4_i     (pc_plus4),
    .branch_taken_i (bus.branch_taken),
    .branch_imm_i   (bus.branch_imm[29:0]),
    .jump_i         (bus.jump),
    .jump_target_i  (bus.jump_target),
    .jump_reg_i     (bus.jump_reg),
    .reg_word_i     (bus.reg_target[31:2]),
    .next_pc_o      (next_pc),
    .sel_o          (sel)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.stall) begin
          pc_d  = next_pc;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (redirect) begin
          pend_d  = next_pc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Newest redirect wins, whether it arrives during or on release of the stall.
        if (bus.stall) begin
          if (redirect) pend_d = next_pc;
        end else begin
          pc_d    = redirect ? next_pc : pend_q;
          cnt_d   = cnt_q + CNT_W'(1);
          pend_d  = '0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (state_q != BOOT && sel == SEL_JR && bus.reg_target[1:0] != 2'b00) err_d = 1'b1;
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.pc_upper     = pc_plus4[31:28];
  assign bus.fetch_valid  = (state_q != BOOT);
  assign bus.misalign_err = err_q;
  assign bus.adv_count    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if #(.CNT_W(32)) bus ();

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] imm;
    logic        j;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_fv;
    logic        exp_err;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] im, input logic jj,
                       input logic [31:0] jtg, input logic r, input logic [31:0] rtg);
    bus.stall        = s;
    bus.branch_taken = b;
    bus.branch_imm   = im;
    bus.jump         = jj;
    bus.jump_target  = jtg;
    bus.jump_reg     = r;
    bus.reg_target   = rtg;
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] im,
                              input logic jj, input logic [31:0] jtg, input logic r,
                              input logic [31:0] rtg, input logic [31:0] p, input logic fv,
                              input logic e, input logic [31:0] c);
    vec_t v;
    v.stall = s; v.br = b; v.imm = im; v.j = jj; v.jt = jtg; v.jr = r; v.rt = rtg;
    v.exp_pc = p; v.exp_fv = fv; v.exp_err = e; v.exp_cnt = c;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_p4;
    total = 0;
    bad   = 0;
    //            stall br imm           j  jt            jr rt            pc            fv err cnt
    vecs[0]  = mk(0, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0000_0000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 0, 1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 0, 2);
    vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 0, 3);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 4);
    vecs[5]  = mk(0, 1, 32'hFFFF_FFFE, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 0, 5);
    vecs[6]  = mk(0, 1, 32'hFFFF_FFFE, 1, 32'h0040_0000, 0, 32'h0,       32'h0040_0000, 1, 0, 6);
    vecs[7]  = mk(1, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0,        32'h0040_0000, 1, 0, 6);
    vecs[8]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0200, 32'h0040_0000, 1, 0, 6);
    vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0040_0000, 1, 0, 6);
    vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 7);
    vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0200, 1, 0, 7);
    vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0204, 1, 0, 8);
    vecs[13] = mk(1, 1, 32'h0000_0004, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 1, 0, 8);
    vecs[14] = mk(0, 0, 32'h0,        1, 32'h0000_3000, 0, 32'h0,        32'h0000_3000, 1, 0, 9);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h1234_5679, 32'h1234_5678, 1, 1, 10);
    vecs[16] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'hFFFF_FFFC, 1, 1, 11);
    vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 1, 12);
    vecs[18] = mk(0, 0, 32'h0,        1, 32'h7FFF_FFFC, 0, 32'h0,        32'h7FFF_FFFC, 1, 1, 13);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h8000_0000, 1, 1, 14);

    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    #12;
    rst = 1'b0;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("reset_err", {31'b0, bus.misalign_err}, 32'h0);
    chk("reset_cnt", bus.adv_count, 32'h0);
    chk("reset_upper", {28'b0, bus.pc_upper}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].imm, vecs[i].j, vecs[i].jt, vecs[i].jr, vecs[i].rt);
      @(posedge clk);
      #1;
      exp_p4 = vecs[i].exp_pc + 32'd4;
      chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc4", i), bus.pc_plus4, exp_p4);
      chk($sformatf("v%0d_upper", i), {28'b0, bus.pc_upper}, {28'b0, exp_p4[31:28]});
      chk($sformatf("v%0d_fv", i), {31'b0, bus.fetch_valid}, {31'b0, vecs[i].exp_fv});
      chk($sformatf("v%0d_err", i), {31'b0, bus.misalign_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_cnt", i), bus.adv_count, vecs[i].exp_cnt);
    end
    chk("upper_at_8000", {28'b0, bus.pc_upper}, 32'h8);

    // Enter HOLD with a pending jump, then reset asynchronously mid-cycle.
    drive(1, 0, 32'h0, 1, 32'h0000_0500, 0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", bus.pc, 32'h0);
    chk("async_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("async_err", {31'b0, bus.misalign_err}, 32'h0);
    chk("async_cnt", bus.adv_count, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("boot_pc", bus.pc, 32'h0);
    chk("boot_fv", {31'b0, bus.fetch_valid}, 32'h1);
    @(posedge clk);
    #1;
    chk("after_boot_pc", bus.pc, 32'h4);
    chk("after_boot_cnt", bus.adv_count, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
